// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline-control slice: control-bundle layout,
// PC-select and forwarding encodings, register-address sizing.
package ctrl_pkg;

   localparam int unsigned REG_AW   = 5;
   localparam int unsigned LINK_REG = 31;
   localparam int unsigned CTRL_W   = 14;

   // Bit positions inside the 14-bit decoder bundle
   localparam int unsigned C_SIGNEXT  = 13;
   localparam int unsigned C_ALUOP_HI = 12;
   localparam int unsigned C_ALUOP_LO = 11;
   localparam int unsigned C_ALUSRC   = 10;
   localparam int unsigned C_MEMREAD  = 9;
   localparam int unsigned C_MEMWRITE = 8;
   localparam int unsigned C_MEMTOREG = 7;
   localparam int unsigned C_REGWRITE = 6;
   localparam int unsigned C_REGDST   = 5;
   localparam int unsigned C_BRANCH   = 4;
   localparam int unsigned C_BRANCHNE = 3;
   localparam int unsigned C_JUMP     = 2;
   localparam int unsigned C_JUMPR    = 1;
   localparam int unsigned C_LINK     = 0;

   typedef logic [CTRL_W-1:0] ctrl_t;
   typedef logic [REG_AW-1:0] reg_t;

   typedef enum logic [1:0] {
      PcPlus4  = 2'b00,
      PcJump   = 2'b01,
      PcJr     = 2'b10,
      PcBranch = 2'b11
   } pc_sel_e;

   typedef enum logic [1:0] {
      FwdReg = 2'b00,
      FwdWb  = 2'b01,
      FwdMem = 2'b10
   } fwd_e;

   function automatic reg_t dest_reg(input ctrl_t c, input reg_t rt, input reg_t rd);
      if (c[C_LINK]) return reg_t'(LINK_REG);
      return c[C_REGDST] ? rd : rt;
   endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-stage inputs and pipeline-control outputs of ctrl_pipe; master is the
// core datapath side, slave is the control pipe.
interface ctrl_pipe_if;
   import ctrl_pkg::*;

   logic       id_valid;
   ctrl_t      id_ctrl;
   reg_t       id_rs;
   reg_t       id_rt;
   reg_t       id_rd;
   logic       ex_zero;

   ctrl_t      ex_ctrl;
   reg_t       ex_rs;
   reg_t       ex_rt;
   logic       mem_memread;
   logic       mem_memwrite;
   logic       wb_regwrite;
   logic       wb_memtoreg;
   reg_t       wb_wreg;
   logic       stall;
   logic       flush_ifid;
   logic [1:0] pc_sel;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   modport master (
      output id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_zero,
      input  ex_ctrl, ex_rs, ex_rt, mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg,
             wb_wreg, stall, flush_ifid, pc_sel, fwd_a, fwd_b
   );

   modport slave (
      input  id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_zero,
      output ex_ctrl, ex_rs, ex_rt, mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg,
             wb_wreg, stall, flush_ifid, pc_sel, fwd_a, fwd_b
   );

endinterface

// File: rtl/hazard_unit.sv
// Combinational hazard logic: load-use and jr stalls, branch resolution,
// PC select and EX operand forwarding selects.
module hazard_unit
   import ctrl_pkg::*;
(
   input  logic    id_valid_i,
   input  ctrl_t   id_ctrl_i,
   input  reg_t    id_rs_i,
   input  reg_t    id_rt_i,
   input  logic    ex_valid_i,
   input  ctrl_t   ex_ctrl_i,
   input  reg_t    ex_rs_i,
   input  reg_t    ex_rt_i,
   input  reg_t    ex_wreg_i,
   input  logic    ex_zero_i,
   input  logic    mem_valid_i,
   input  logic    mem_regwrite_i,
   input  logic    mem_memread_i,
   input  reg_t    mem_wreg_i,
   input  logic    wb_regwrite_i,
   input  reg_t    wb_wreg_i,
   output logic    stall_o,
   output logic    branch_taken_o,
   output logic    flush_ifid_o,
   output pc_sel_e pc_sel_o,
   output fwd_e    fwd_a_o,
   output fwd_e    fwd_b_o
);

   logic uses_rs, uses_rt;
   logic ex_wreg_nz, mem_wreg_nz, wb_wreg_nz;
   logic load_use, id_jr, jr_stall, id_jump;
   logic mem_fwd, wb_fwd;

   assign uses_rt = ~id_ctrl_i[C_ALUSRC] | id_ctrl_i[C_MEMWRITE] | id_ctrl_i[C_BRANCH];
   assign uses_rs = ~(id_ctrl_i[C_JUMP] & ~id_ctrl_i[C_JUMPR]);

   // Register 0 is never a real producer, so it never creates a hazard
   assign ex_wreg_nz  = (ex_wreg_i != '0);
   assign mem_wreg_nz = (mem_wreg_i != '0);
   assign wb_wreg_nz  = (wb_wreg_i != '0);

   assign load_use = id_valid_i & ex_valid_i & ex_ctrl_i[C_MEMREAD] & ex_wreg_nz &
                     ((uses_rs & (ex_wreg_i == id_rs_i)) | (uses_rt & (ex_wreg_i == id_rt_i)));

   // jr resolves in ID, so it must wait out any producer still in EX or a load in MEM
   assign id_jr    = id_valid_i & id_ctrl_i[C_JUMP] & id_ctrl_i[C_JUMPR];
   assign jr_stall = id_jr &
                     ((ex_valid_i & ex_ctrl_i[C_REGWRITE] & ex_wreg_nz & (ex_wreg_i == id_rs_i)) |
                      (mem_valid_i & mem_memread_i & mem_wreg_nz & (mem_wreg_i == id_rs_i)));

   assign branch_taken_o = ex_valid_i & ex_ctrl_i[C_BRANCH] & (ex_zero_i ^ ex_ctrl_i[C_BRANCHNE]);
   assign stall_o        = (load_use | jr_stall) & ~branch_taken_o;
   assign id_jump        = id_valid_i & id_ctrl_i[C_JUMP] & ~stall_o & ~branch_taken_o;

   always_comb begin
      pc_sel_o     = PcPlus4;
      flush_ifid_o = 1'b0;
      if (branch_taken_o) begin
         pc_sel_o     = PcBranch;
         flush_ifid_o = 1'b1;
      end else if (id_jump) begin
         pc_sel_o     = id_ctrl_i[C_JUMPR] ? PcJr : PcJump;
         flush_ifid_o = 1'b1;
      end
   end

   // Loads in MEM have no data yet; they are covered by the load-use stall
   assign mem_fwd = mem_valid_i & mem_regwrite_i & mem_wreg_nz & ~mem_memread_i;
   assign wb_fwd  = wb_regwrite_i & wb_wreg_nz;

   assign fwd_a_o = (mem_fwd & (mem_wreg_i == ex_rs_i)) ? FwdMem :
                    (wb_fwd  & (wb_wreg_i  == ex_rs_i)) ? FwdWb  : FwdReg;
   assign fwd_b_o = (mem_fwd & (mem_wreg_i == ex_rt_i)) ? FwdMem :
                    (wb_fwd  & (wb_wreg_i  == ex_rt_i)) ? FwdWb  : FwdReg;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded control through ID/EX, EX/MEM and MEM/WB and drives the
// stall, flush, PC-select and forwarding controls of the 5-stage core.
module ctrl_pipe
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   ctrl_pipe_if.slave  bus
);

   logic    ex_valid_q, ex_valid_d;
   ctrl_t   ex_ctrl_q, ex_ctrl_d;
   reg_t    ex_rs_q, ex_rs_d;
   reg_t    ex_rt_q, ex_rt_d;
   reg_t    ex_wreg_q, ex_wreg_d;

   logic    mem_valid_q, mem_memread_q, mem_memwrite_q, mem_memtoreg_q, mem_regwrite_q;
   reg_t    mem_wreg_q;

   logic    wb_regwrite_q, wb_memtoreg_q;
   reg_t    wb_wreg_q;

   logic    stall, branch_taken, flush_ifid;
   pc_sel_e pc_sel;
   fwd_e    fwd_a, fwd_b;
   logic    ex_load;

   hazard_unit u_hazard (
      .id_valid_i     (bus.id_valid),
      .id_ctrl_i      (bus.id_ctrl),
      .id_rs_i        (bus.id_rs),
      .id_rt_i        (bus.id_rt),
      .ex_valid_i     (ex_valid_q),
      .ex_ctrl_i      (ex_ctrl_q),
      .ex_rs_i        (ex_rs_q),
      .ex_rt_i        (ex_rt_q),
      .ex_wreg_i      (ex_wreg_q),
      .ex_zero_i      (bus.ex_zero),
      .mem_valid_i    (mem_valid_q),
      .mem_regwrite_i (mem_regwrite_q),
      .mem_memread_i  (mem_memread_q),
      .mem_wreg_i     (mem_wreg_q),
      .wb_regwrite_i  (wb_regwrite_q),
      .wb_wreg_i      (wb_wreg_q),
      .stall_o        (stall),
      .branch_taken_o (branch_taken),
      .flush_ifid_o   (flush_ifid),
      .pc_sel_o       (pc_sel),
      .fwd_a_o        (fwd_a),
      .fwd_b_o        (fwd_b)
   );

   // Stall and taken branch both turn the ID/EX slot into a bubble
   assign ex_load = bus.id_valid & ~stall & ~branch_taken;

   always_comb begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_wreg_d  = '0;
      if (ex_load) begin
         ex_valid_d = 1'b1;
         ex_ctrl_d  = bus.id_ctrl;
         ex_rs_d    = bus.id_rs;
         ex_rt_d    = bus.id_rt;
         ex_wreg_d  = dest_reg(bus.id_ctrl, bus.id_rt, bus.id_rd);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q     <= 1'b0;
         ex_ctrl_q      <= '0;
         ex_rs_q        <= '0;
         ex_rt_q        <= '0;
         ex_wreg_q      <= '0;
         mem_valid_q    <= 1'b0;
         mem_memread_q  <= 1'b0;
         mem_memwrite_q <= 1'b0;
         mem_memtoreg_q <= 1'b0;
         mem_regwrite_q <= 1'b0;
         mem_wreg_q     <= '0;
         wb_regwrite_q  <= 1'b0;
         wb_memtoreg_q  <= 1'b0;
         wb_wreg_q      <= '0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_ctrl_q      <= ex_ctrl_d;
         ex_rs_q        <= ex_rs_d;
         ex_rt_q        <= ex_rt_d;
         ex_wreg_q      <= ex_wreg_d;
         mem_valid_q    <= ex_valid_q;
         mem_memread_q  <= ex_ctrl_q[C_MEMREAD];
         mem_memwrite_q <= ex_ctrl_q[C_MEMWRITE];
         mem_memtoreg_q <= ex_ctrl_q[C_MEMTOREG];
         mem_regwrite_q <= ex_ctrl_q[C_REGWRITE];
         mem_wreg_q     <= ex_wreg_q;
         wb_regwrite_q  <= mem_regwrite_q;
         wb_memtoreg_q  <= mem_memtoreg_q;
         wb_wreg_q      <= mem_wreg_q;
      end
   end

   assign bus.ex_ctrl      = ex_ctrl_q;
   assign bus.ex_rs        = ex_rs_q;
   assign bus.ex_rt        = ex_rt_q;
   assign bus.mem_memread  = mem_memread_q;
   assign bus.mem_memwrite = mem_memwrite_q;
   assign bus.wb_regwrite  = wb_regwrite_q;
   assign bus.wb_memtoreg  = wb_memtoreg_q;
   assign bus.wb_wreg      = wb_wreg_q;

   // ID-driven jump decode is combinational, so hold it quiet during reset
   assign bus.stall      = rst_n & stall;
   assign bus.flush_ifid = rst_n & flush_ifid;
   assign bus.pc_sel     = rst_n ? pc_sel : PcPlus4;
   assign bus.fwd_a      = rst_n ? fwd_a : FwdReg;
   assign bus.fwd_b      = rst_n ? fwd_b : FwdReg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: the driver queues per-cycle expectations,
// a negedge monitor compares every entry due in the current cycle.
module tb_ctrl_pipe;
   import ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ctrl_pipe_if bus ();

   ctrl_pipe u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Bundle: {signext,aluop[1:0],alusrc,memread,memwrite,memtoreg,regwrite,regdst,
   //          branch,branchne,jump,jumpr,link}
   localparam ctrl_t OpAdd  = 14'h1060;  // aluop=10, regwrite, regdst
   localparam ctrl_t OpLw   = 14'h26C0;  // signext, alusrc, memread, memtoreg, regwrite
   localparam ctrl_t OpAddi = 14'h2440;  // signext, alusrc, regwrite
   localparam ctrl_t OpBeq  = 14'h0810;  // aluop=01, branch
   localparam ctrl_t OpBne  = 14'h0818;  // aluop=01, branch, branchne
   localparam ctrl_t OpJal  = 14'h0045;  // regwrite, jump, link
   localparam ctrl_t OpJr   = 14'h0006;  // jump, jumpr

   typedef enum {KStall, KFlush, KPcSel, KFwdA, KFwdB, KExCtrl, KWbRw, KWbWreg, KAll} kind_e;

   typedef struct {
      int unsigned cyc;
      kind_e       kind;
      logic [13:0] val;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [13:0] act;

   function automatic logic [13:0] actual(input kind_e k);
      case (k)
         KStall:  return 14'(bus.stall);
         KFlush:  return 14'(bus.flush_ifid);
         KPcSel:  return 14'(bus.pc_sel);
         KFwdA:   return 14'(bus.fwd_a);
         KFwdB:   return 14'(bus.fwd_b);
         KExCtrl: return bus.ex_ctrl;
         KWbRw:   return 14'(bus.wb_regwrite);
         KWbWreg: return 14'(bus.wb_wreg);
         default: return 14'(|{bus.stall, bus.flush_ifid, bus.pc_sel, bus.fwd_a, bus.fwd_b,
                               bus.ex_ctrl, bus.ex_rs, bus.ex_rt, bus.mem_memread,
                               bus.mem_memwrite, bus.wb_regwrite, bus.wb_memtoreg,
                               bus.wb_wreg});
      endcase
   endfunction

   task automatic expect_at(input int unsigned dly, input kind_e k, input logic [13:0] v,
                            input string nm);
      exp_t e;
      e.cyc  = cyc + dly;
      e.kind = k;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic issue(input logic v, input ctrl_t c, input int rs, input int rt, input int rd,
                        input logic z = 1'b0);
      @(posedge clk);
      #1;
      cyc++;
      bus.id_valid = v;
      bus.id_ctrl  = c;
      bus.id_rs    = reg_t'(rs);
      bus.id_rt    = reg_t'(rt);
      bus.id_rd    = reg_t'(rd);
      bus.ex_zero  = z;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, '0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            act = actual(sb[i].kind);
            total++;
            if (act !== sb[i].val) begin
               bad++;
               $display("FAIL %s (cycle %0d): got %h, expected %h", sb[i].name, cyc, act,
                        sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n        = 1'b0;
      bus.id_valid = 1'b0;
      bus.id_ctrl  = '0;
      bus.id_rs    = '0;
      bus.id_rt    = '0;
      bus.id_rd    = '0;
      bus.ex_zero  = 1'b0;
      expect_at(0, KAll, 0, "reset_outputs_zero");
      repeat (2) @(negedge clk);
      total++;
      if (bus.stall !== 1'b0) begin
         bad++;
         $display("FAIL reset_stall_low: got %b", bus.stall);
      end
      total++;
      if (bus.pc_sel !== 2'b00) begin
         bad++;
         $display("FAIL reset_pc_sel_zero: got %b", bus.pc_sel);
      end
      total++;
      if (bus.ex_ctrl !== 14'h0000) begin
         bad++;
         $display("FAIL reset_ex_ctrl_zero: got %h", bus.ex_ctrl);
      end
      total++;
      if (bus.wb_wreg !== 5'd0) begin
         bad++;
         $display("FAIL reset_wb_wreg_zero: got %h", bus.wb_wreg);
      end
      #1 rst_n = 1'b1;

      // lw $2 ; add $3,$2,$4 -> one bubble, then WB forwarding
      issue(1, OpLw, 1, 2, 0);   expect_at(0, KStall, 0, "lw_alone_no_stall");
      issue(1, OpAdd, 2, 4, 3);  expect_at(0, KStall, 1, "loaduse_stall");
                                 expect_at(0, KFlush, 0, "loaduse_no_flush");
      issue(1, OpAdd, 2, 4, 3);  expect_at(0, KStall, 0, "loaduse_stall_one_cycle");
                                 expect_at(0, KExCtrl, 0, "loaduse_bubble");
      issue(0, '0, 0, 0, 0);     expect_at(0, KFwdA, 1, "loaduse_fwd_a_wb");
                                 expect_at(0, KFwdB, 0, "loaduse_fwd_b_none");
                                 expect_at(0, KExCtrl, OpAdd, "loaduse_add_in_ex");
      idle(3);

      // add $2 ; sub $5,$2,$2 -> MEM forwarding on both operands
      issue(1, OpAdd, 6, 7, 2);
      issue(1, OpAdd, 2, 2, 5);  expect_at(0, KStall, 0, "raw_alu_no_stall");
      issue(0, '0, 0, 0, 0);     expect_at(0, KFwdA, 2, "raw_fwd_a_mem");
                                 expect_at(0, KFwdB, 2, "raw_fwd_b_mem");
      idle(3);

      // one unrelated instruction between -> WB forwarding
      issue(1, OpAdd, 6, 7, 2);
      issue(1, OpAdd, 8, 9, 10);
      issue(1, OpAdd, 2, 2, 5);
      issue(0, '0, 0, 0, 0);     expect_at(0, KFwdA, 1, "gap_fwd_a_wb");
                                 expect_at(0, KFwdB, 1, "gap_fwd_b_wb");
      idle(3);

      // $2 produced in both MEM and WB -> MEM wins
      issue(1, OpAdd, 6, 7, 2);
      issue(1, OpAdd, 8, 9, 2);
      issue(1, OpAdd, 2, 2, 5);
      issue(0, '0, 0, 0, 0);     expect_at(0, KFwdA, 2, "mem_priority_fwd_a");
      idle(3);

      // beq taken in EX
      issue(1, OpBeq, 1, 2, 0);
      issue(1, OpAdd, 3, 4, 5, 1); expect_at(0, KPcSel, 3, "beq_pc_sel");
                                   expect_at(0, KFlush, 1, "beq_flush");
      issue(0, '0, 0, 0, 0);       expect_at(0, KExCtrl, 0, "beq_squash_bubble");
      idle(3);

      // bne with zero=1 is not taken
      issue(1, OpBne, 1, 2, 0);
      issue(0, '0, 0, 0, 0, 1);    expect_at(0, KPcSel, 0, "bne_not_taken_pc_sel");
                                   expect_at(0, KFlush, 0, "bne_not_taken_flush");
      idle(3);

      // jal -> jump target now, $31 written back three edges later
      issue(1, OpJal, 0, 0, 0);  expect_at(0, KPcSel, 1, "jal_pc_sel");
                                 expect_at(0, KFlush, 1, "jal_flush");
                                 expect_at(3, KWbWreg, 31, "jal_wb_wreg");
                                 expect_at(3, KWbRw, 1, "jal_wb_regwrite");
      idle(4);

      // lw $4 ; jr $4 -> two stall cycles, then register jump
      issue(1, OpLw, 1, 4, 0);
      issue(1, OpJr, 4, 0, 0);   expect_at(0, KStall, 1, "jr_stall_1");
                                 expect_at(0, KFlush, 0, "jr_stall_no_flush");
      issue(1, OpJr, 4, 0, 0);   expect_at(0, KStall, 1, "jr_stall_2");
      issue(1, OpJr, 4, 0, 0);   expect_at(0, KStall, 0, "jr_released");
                                 expect_at(0, KPcSel, 2, "jr_pc_sel");
                                 expect_at(0, KFlush, 1, "jr_flush");
      idle(4);

      // taken beq in EX while ID jr waits on a load in MEM -> flush wins
      issue(1, OpLw, 1, 4, 0);
      issue(1, OpBeq, 6, 7, 0);
      issue(1, OpJr, 4, 0, 0, 1); expect_at(0, KStall, 0, "branch_over_stall");
                                  expect_at(0, KPcSel, 3, "branch_over_stall_pc_sel");
                                  expect_at(0, KFlush, 1, "branch_over_stall_flush");
      issue(0, '0, 0, 0, 0);      expect_at(0, KExCtrl, 0, "branch_over_stall_bubble");
      idle(4);

      // register 0 never forwards or stalls
      issue(1, OpAddi, 1, 0, 0);
      issue(1, OpAdd, 0, 0, 3);  expect_at(0, KStall, 0, "r0_no_stall");
      issue(0, '0, 0, 0, 0);     expect_at(0, KFwdA, 0, "r0_no_fwd_a");
                                 expect_at(0, KFwdB, 0, "r0_no_fwd_b");
      idle(3);
      issue(1, OpLw, 1, 0, 0);
      issue(1, OpAdd, 0, 0, 3);  expect_at(0, KStall, 0, "lw_r0_no_stall");
      idle(4);

      // async reset in the middle of a jr stall discards in-flight state
      issue(1, OpLw, 1, 4, 0);
      issue(1, OpJr, 4, 0, 0);   expect_at(0, KStall, 1, "pre_reset_stall");
      issue(1, OpJr, 4, 0, 0);
      rst_n = 1'b0;              expect_at(0, KAll, 0, "async_reset_outputs_zero");
      #1;
      total++;
      if (bus.stall !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_stall_low: got %b", bus.stall);
      end
      total++;
      if (bus.flush_ifid !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_flush_low: got %b", bus.flush_ifid);
      end
      issue(1, OpJr, 4, 0, 0);
      rst_n = 1'b1;              expect_at(0, KStall, 0, "post_reset_no_stall");
                                 expect_at(0, KPcSel, 2, "post_reset_jr_pc_sel");
      idle(4);

      repeat (2) @(negedge clk);
      #1;
      foreach (sb[i]) begin
         total++;
         bad++;
         $display("FAIL %s: never checked, expected %h at cycle %0d", sb[i].name, sb[i].val,
                  sb[i].cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
